// File: rtl/adaptive_filter_out_fifo.sv
// Output buffer behind the adaptive filter: turns a no-backpressure sample stream
// into an AXI-Stream master with a registered first-word-fall-through output stage.
`timescale 1ns/1ps

module adaptive_filter_out_fifo #(
    parameter int WORDLENGTH   = 14,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [WORDLENGTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tuser,
    output logic [WORDLENGTH-1:0]    m_tdata,
    output logic                     m_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     afull,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 4");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("AFULL_THRESH must lie in 1..DEPTH");
    end

    // Handshake: the input side has no ready, a sample is offered on every s_tvalid
    // cycle; the output transfers on any edge where m_tvalid && m_tready.
    logic [WORDLENGTH:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       rd_ptr_nxt;
    logic [PW-1:0]       level_nxt;
    logic [PW-1:0]       stored_after_pop;
    logic [WORDLENGTH:0] head_word;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;

    // The entry on m_tdata still occupies its memory slot, so the pointer
    // difference is the full occupancy including the presented word.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == DEPTH_L);
    assign pop   = m_tvalid && m_tready;
    assign push  = s_tvalid && (!full || pop);
    assign drop  = s_tvalid && full && !pop;

    always_comb begin
        rd_ptr_nxt       = rd_ptr + PW'(pop);
        stored_after_pop = level - PW'(pop);
        level_nxt        = stored_after_pop + PW'(push);
        // An empty buffer forwards the incoming sample straight to the output register.
        if (stored_after_pop == '0) begin
            head_word = {s_tuser, s_tdata};
        end else begin
            head_word = mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_tuser, s_tdata};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tuser  <= 1'b0;
            afull    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PW'(push);
            rd_ptr   <= rd_ptr_nxt;
            m_tvalid <= (level_nxt != '0);
            if (level_nxt != '0) begin
                {m_tuser, m_tdata} <= head_word;
            end
            afull <= (level_nxt >= AFULL_L);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
